mmp_modexp_sched: RTL

MMP_MODEXP_SCHED -- requirements
Module: mmp_modexp_sched

---
 rtl/mmp_modexp_sched_if.sv | 43 ++++
 rtl/mmp_modexp_sched.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mmp_modexp_sched_if.sv
// Host configuration, result read-back and Montgomery-core handshake for mmp_modexp_sched.
// The slave modport is the scheduler's view; the master modport is the host/core side.
interface mmp_modexp_sched_if #(
  parameter int K      = 128,
  parameter int ADDR_W = 4,
  parameter int EB_W   = 12
);
  logic              cfg_wr;
  logic [1:0]        cfg_sel;
  logic [ADDR_W-1:0] cfg_addr;
  logic [K-1:0]      cfg_data;
  logic [K-1:0]      m1;
  logic [EB_W-1:0]   exp_bits;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [K-1:0]      rd_data;
  logic [2:0]        mm_wr_ena;
  logic [ADDR_W-1:0] mm_wr_addr;
  logic [K-1:0]      mm_wr_x;
  logic [K-1:0]      mm_wr_y;
  logic [K-1:0]      mm_wr_m;
  logic [K-1:0]      mm_wr_m1;
  logic              mm_task_req;
  logic              mm_task_grant;
  logic [K-1:0]      mm_task_res;
  logic              mm_task_end;

  modport slave (
    input  cfg_wr, cfg_sel, cfg_addr, cfg_data, m1, exp_bits, start, rd_addr,
           mm_task_grant, mm_task_res, mm_task_end,
    output busy, done, rd_data, mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m,
           mm_wr_m1, mm_task_req
  );

  modport master (
    output cfg_wr, cfg_sel, cfg_addr, cfg_data, m1, exp_bits, start, rd_addr,
           mm_task_grant, mm_task_res, mm_task_end,
    input  busy, done, rd_data, mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m,
           mm_wr_m1, mm_task_req
  );
endinterface

// File: rtl/mmp_modexp_sched.sv
// Left-to-right Montgomery exponentiation scheduler: streams operands into an external
// Montgomery-multiply core word by word and collects its result back into ACC.
module mmp_modexp_sched #(
  parameter int K      = 128,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N),
  parameter int EB_W   = $clog2(K*N) + 1
) (
  input logic clk,
  input logic rst_n,
  mmp_modexp_sched_if.slave bus
);

  localparam int                KB        = $clog2(K);
  localparam logic [EB_W-1:0]   MAX_BITS  = EB_W'(K * N);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   N_WORDS   = (ADDR_W + 1)'(N);

  typedef enum logic [2:0] {
    IDLE, LOAD_M, LOAD_XY, REQ, WAIT, NEXT, FIN
  } state_t;

  state_t state, state_nxt;

  logic [K-1:0] base_mem [N];
  logic [K-1:0] acc_mem  [N];
  logic [K-1:0] mod_mem  [N];
  logic [K-1:0] exp_mem  [N];

  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W:0]   res_cnt;
  logic [EB_W-1:0]   bit_idx;
  logic              is_mul;
  logic              busy_q;
  logic              done_q;
  logic [K-1:0]      rd_q;
  logic [2:0]        wr_ena;
  logic              task_req;

  logic              last_word;
  logic [ADDR_W-1:0] bit_word;
  logic [KB-1:0]     bit_pos;
  logic              exp_bit;
  logic [EB_W-1:0]   eb_sat;
  logic              cfg_take;
  logic              grant_take;

  assign last_word  = (word_cnt == LAST_WORD);
  assign bit_word   = ADDR_W'(bit_idx >> KB);
  assign bit_pos    = bit_idx[KB-1:0];
  assign exp_bit    = exp_mem[bit_word][bit_pos];
  assign eb_sat     = (bus.exp_bits > MAX_BITS) ? MAX_BITS : bus.exp_bits;
  assign cfg_take   = bus.cfg_wr && !busy_q;
  assign grant_take = (state == WAIT) && bus.mm_task_grant && (res_cnt < N_WORDS);

  // NOTE: operand buffers have no reset; clearing a RAM costs a port and the host reloads them anyway.
  always_ff @(posedge clk) begin
    if (cfg_take) begin
      case (bus.cfg_sel)
        2'd0:    base_mem[bus.cfg_addr] <= bus.cfg_data;
        2'd1:    acc_mem[bus.cfg_addr]  <= bus.cfg_data;
        2'd2:    mod_mem[bus.cfg_addr]  <= bus.cfg_data;
        default: exp_mem[bus.cfg_addr]  <= bus.cfg_data;
      endcase
    end
    if (grant_take) acc_mem[res_cnt[ADDR_W-1:0]] <= bus.mm_task_res;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    wr_ena    = 3'b000;
    task_req  = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.exp_bits != '0) ? LOAD_M : FIN;
      LOAD_M: begin
        wr_ena = 3'b100;
        if (last_word) state_nxt = LOAD_XY;
      end
      LOAD_XY: begin
        wr_ena = 3'b011;
        if (last_word) state_nxt = REQ;
      end
      REQ: begin
        task_req  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (bus.mm_task_end) state_nxt = NEXT;
      NEXT: begin
        if (!is_mul && exp_bit)  state_nxt = LOAD_XY;
        else if (bit_idx == '0)  state_nxt = FIN;
        else                     state_nxt = LOAD_XY;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      res_cnt  <= '0;
      bit_idx  <= '0;
      is_mul   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == FIN);
      rd_q   <= acc_mem[bus.rd_addr];
      case (state)
        IDLE: begin
          if (bus.start && bus.exp_bits != '0) begin
            busy_q   <= 1'b1;
            bit_idx  <= eb_sat - EB_W'(1);
            is_mul   <= 1'b0;
            word_cnt <= '0;
          end
        end
        LOAD_M, LOAD_XY: word_cnt <= last_word ? '0 : word_cnt + ADDR_W'(1);
        REQ:             res_cnt  <= '0;
        WAIT:            if (grant_take) res_cnt <= res_cnt + (ADDR_W + 1)'(1);
        NEXT: begin
          // A set bit turns the square just finished into square-then-multiply.
          if (!is_mul && exp_bit) begin
            is_mul <= 1'b1;
          end else begin
            is_mul <= 1'b0;
            if (bit_idx != '0) bit_idx <= bit_idx - EB_W'(1);
          end
        end
        FIN:             busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_data     = rd_q;
  assign bus.mm_wr_ena   = wr_ena;
  assign bus.mm_task_req = task_req;
  assign bus.mm_wr_addr  = word_cnt;
  assign bus.mm_wr_x     = acc_mem[word_cnt];
  assign bus.mm_wr_y     = is_mul ? base_mem[word_cnt] : acc_mem[word_cnt];
  assign bus.mm_wr_m     = mod_mem[word_cnt];
  assign bus.mm_wr_m1    = bus.m1;

endmodule
